// File: rtl/i2s_receiver.sv
// -----------------------------------------------------------------------------
// i2s_receiver
//
// I2S bus-master receiver. Divides mclk down to the serial bit clock (sclk)
// and the word-select clock (ws), samples sd_rx on every sclk rising edge,
// and presents a complete left/right stereo pair with a one-mclk rx_valid
// strobe.
//
// Ports
//   mclk       in   main clock, all logic on the rising edge
//   rst        in   asynchronous, active-high reset
//   sd_rx      in   serial data from the codec, MSB first, one-bit I2S delay
//   sclk       out  serial bit clock (MAIN_TO_SERIAL mclk cycles per period)
//   ws         out  word select, 0 = left, 1 = right
//   rx_data_l  out  last complete left word
//   rx_data_r  out  last complete right word of the same frame
//   rx_valid   out  one-mclk pulse when a new pair is presented
// -----------------------------------------------------------------------------
module i2s_receiver #(
    parameter int WIDTH                = 16,
    parameter int MAIN_TO_SERIAL       = 8,
    parameter int SERIAL_TO_LEFT_RIGHT = 64
) (
    input  logic             mclk,
    input  logic             rst,
    input  logic             sd_rx,
    output logic             sclk,
    output logic             ws,
    output logic [WIDTH-1:0] rx_data_l,
    output logic [WIDTH-1:0] rx_data_r,
    output logic             rx_valid
);

    localparam int DIV_HALF   = MAIN_TO_SERIAL / 2;
    localparam int DIV_W      = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
    localparam int HALF_FRAME = SERIAL_TO_LEFT_RIGHT / 2;
    // One spare bit so a slot count equal to HALF_FRAME never aliases to 0.
    localparam int SLOT_W     = $clog2(HALF_FRAME) + 1;

    logic [DIV_W-1:0]  div_cnt;
    logic [SLOT_W-1:0] fall_cnt;
    logic [SLOT_W-1:0] slot_cnt;

    logic              div_tc;
    logic              sclk_rise;
    logic              sclk_fall;
    logic              ws_toggle;
    logic              in_word;
    logic              lsb_slot;

    logic [WIDTH-1:0]  left_sr_p0;
    logic [WIDTH-1:0]  right_sr_p0;
    logic [WIDTH-1:0]  shadow_l_p0;
    logic              left_ok_p0;
    logic              vld_p0;

    // sclk edges are decided one cycle ahead: the edge that toggles sclk is
    // the edge that sees div_cnt at its terminal value.
    always_comb begin
        div_tc    = (div_cnt == DIV_W'(DIV_HALF - 1));
        sclk_rise = div_tc && !sclk;
        sclk_fall = div_tc && sclk;
        ws_toggle = sclk_fall && (fall_cnt == SLOT_W'(HALF_FRAME - 1));
        // Slot 0 carries the delayed LSB of the previous word; slots past
        // WIDTH are padding.
        in_word   = sclk_rise && (slot_cnt >= SLOT_W'(1)) && (slot_cnt <= SLOT_W'(WIDTH));
        lsb_slot  = sclk_rise && (slot_cnt == SLOT_W'(WIDTH));
    end

    // Clock generation: sclk divider, ws divider, slot index
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            sclk     <= 1'b0;
            fall_cnt <= '0;
            ws       <= 1'b0;
            slot_cnt <= '0;
        end else begin
            if (div_tc) begin
                div_cnt <= '0;
                sclk    <= ~sclk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (sclk_fall) begin
                if (ws_toggle) begin
                    fall_cnt <= '0;
                    ws       <= ~ws;
                end else begin
                    fall_cnt <= fall_cnt + 1'b1;
                end
            end

            // Reset release behaves as a ws transition: slot_cnt starts at 0.
            if (ws_toggle) begin
                slot_cnt <= '0;
            end else if (sclk_rise) begin
                slot_cnt <= slot_cnt + 1'b1;
            end
        end
    end

    // Stage p0: bit capture, left shadow, pair pairing
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            left_sr_p0  <= '0;
            right_sr_p0 <= '0;
            shadow_l_p0 <= '0;
            left_ok_p0  <= 1'b0;
            vld_p0      <= 1'b0;
        end else begin
            vld_p0 <= 1'b0;

            if (in_word) begin
                if (!ws) begin
                    left_sr_p0 <= {left_sr_p0[WIDTH-2:0], sd_rx};
                end else begin
                    right_sr_p0 <= {right_sr_p0[WIDTH-2:0], sd_rx};
                end
            end

            if (lsb_slot && !ws) begin
                shadow_l_p0 <= {left_sr_p0[WIDTH-2:0], sd_rx};
                left_ok_p0  <= 1'b1;
            end else if (lsb_slot && ws) begin
                // A right word only forms a pair with a left word captured
                // earlier in the same frame.
                vld_p0     <= left_ok_p0;
                left_ok_p0 <= 1'b0;
            end else if (ws_toggle && ws) begin
                // New frame begins: forget any stale left word.
                left_ok_p0 <= 1'b0;
            end
        end
    end

    // Stage p1: present the pair
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            rx_data_l <= '0;
            rx_data_r <= '0;
            rx_valid  <= 1'b0;
        end else begin
            rx_valid <= vld_p0;
            if (vld_p0) begin
                rx_data_l <= shadow_l_p0;
                rx_data_r <= right_sr_p0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_receiver.sv
// -----------------------------------------------------------------------------
// tb_i2s_receiver
//
// Directed bench for i2s_receiver at default parameters. An I2S codec model
// drives sd_rx from per-frame word tables; every mclk edge after reset release
// is numbered and the DUT outputs are recorded per edge for the scenario
// tasks to compare against hand-computed values.
// -----------------------------------------------------------------------------
module tb_i2s_receiver;

    localparam int HIST = 4096;

    logic        mclk = 1'b0;
    logic        rst  = 1'b1;
    logic        sd_rx = 1'b0;
    logic        sclk;
    logic        ws;
    logic [15:0] rx_data_l;
    logic [15:0] rx_data_r;
    logic        rx_valid;

    int checks = 0;
    int errors = 0;
    int edge_no = 0;
    int frame_ofs = 0;
    int rst_vld = 0;

    logic        sclk_h [0:HIST-1];
    logic        ws_h   [0:HIST-1];
    logic        vld_h  [0:HIST-1];
    logic [15:0] dl_h   [0:HIST-1];
    logic [15:0] dr_h   [0:HIST-1];

    // Frame tables: left word, right word, value driven in unused slots.
    logic [15:0] fl   [0:5] = '{16'hA5C3, 16'h0001, 16'h0000, 16'hFFFF, 16'h5555, 16'h1234};
    logic [15:0] fr   [0:5] = '{16'h3C5A, 16'h8000, 16'h0000, 16'hFFFF, 16'hAAAA, 16'hFEDC};
    logic        fill [0:5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    i2s_receiver #(
        .WIDTH(16),
        .MAIN_TO_SERIAL(8),
        .SERIAL_TO_LEFT_RIGHT(64)
    ) dut (
        .mclk(mclk),
        .rst(rst),
        .sd_rx(sd_rx),
        .sclk(sclk),
        .ws(ws),
        .rx_data_l(rx_data_l),
        .rx_data_r(rx_data_r),
        .rx_valid(rx_valid)
    );

    always #5 mclk = ~mclk;

    // Codec model: value on sd_rx at mclk edge e. sclk rises at 4+8k; rising
    // edge k is slot r = k%32 of half-frame k/32 (even = left, odd = right).
    function automatic logic sd_bit(input int e);
        int k, half, r, f;
        logic [15:0] w;
        if (e < 4 || ((e - 4) % 8) != 0) return 1'b0;
        k    = (e - 4) / 8;
        half = k / 32;
        r    = k % 32;
        f    = frame_ofs + half / 2;
        if (f > 5) f = 5;
        w    = (half % 2 == 1) ? fr[f] : fl[f];
        if (r >= 1 && r <= 16) return w[16 - r];
        return fill[f];
    endfunction

    task automatic tick();
        @(posedge mclk);
        #1;
        edge_no++;
        if (rst) begin
            if (rx_valid) rst_vld++;
        end else if (edge_no < HIST) begin
            sclk_h[edge_no] = sclk;
            ws_h[edge_no]   = ws;
            vld_h[edge_no]  = rx_valid;
            dl_h[edge_no]   = rx_data_l;
            dr_h[edge_no]   = rx_data_r;
        end
        sd_rx = sd_bit(edge_no + 1);
    endtask

    task automatic run_to(input int n);
        while (edge_no < n) tick();
    endtask

    task automatic release_reset();
        @(negedge mclk);
        rst = 1'b0;
        edge_no = 0;
        sd_rx = 1'b0;
        for (int i = 0; i < HIST; i++) vld_h[i] = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        repeat (3) tick();
        release_reset();
        run_to(5);
        checks++;
        if (sclk !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_sclk: sclk=%b expected 1", sclk);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({sclk, ws, rx_valid, rx_data_l, rx_data_r} !== 35'd0) begin
            errors++;
            $display("FAIL reset_async: sclk=%b ws=%b vld=%b l=%h r=%h expected all 0",
                     sclk, ws, rx_valid, rx_data_l, rx_data_r);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if ({sclk, ws, rx_valid, rx_data_l, rx_data_r} !== 35'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_hold: %0d nonzero cycles, expected 0", bad);
        end
        release_reset();
    endtask

    task automatic test_clock();
        int glitch, wsbad;
        run_to(600);
        checks++;
        if ({sclk_h[3], sclk_h[4], sclk_h[8], sclk_h[12], sclk_h[20]} !== 5'b01011) begin
            errors++;
            $display("FAIL sclk_edges: e3,4,8,12,20=%b%b%b%b%b expected 01011",
                     sclk_h[3], sclk_h[4], sclk_h[8], sclk_h[12], sclk_h[20]);
        end
        glitch = 0;
        wsbad = 0;
        for (int e = 1; e <= 600; e++) begin
            if (sclk_h[e] !== ((e % 8) >= 4)) glitch++;
            if (ws_h[e] !== ((e / 256) % 2 == 1)) wsbad++;
        end
        checks++;
        if (glitch !== 0) begin
            errors++;
            $display("FAIL sclk_shape: %0d wrong edges, expected 0", glitch);
        end
        checks++;
        if ({ws_h[255], ws_h[256], ws_h[511], ws_h[512]} !== 4'b0110) begin
            errors++;
            $display("FAIL ws_edges: e255,256,511,512=%b%b%b%b expected 0110",
                     ws_h[255], ws_h[256], ws_h[511], ws_h[512]);
        end
        checks++;
        if (wsbad !== 0) begin
            errors++;
            $display("FAIL ws_shape: %0d wrong edges, expected 0", wsbad);
        end
    endtask

    task automatic test_single_pair();
        int extra;
        run_to(600);
        extra = 0;
        for (int e = 1; e <= 600; e++) if (e != 389 && vld_h[e] !== 1'b0) extra++;
        checks++;
        if (vld_h[389] !== 1'b1 || extra !== 0) begin
            errors++;
            $display("FAIL single_valid: vld@389=%b stray=%0d expected 1 and 0", vld_h[389], extra);
        end
        checks++;
        if (dl_h[389] !== 16'hA5C3 || dr_h[389] !== 16'h3C5A) begin
            errors++;
            $display("FAIL single_data: l=%h r=%h expected a5c3 3c5a", dl_h[389], dr_h[389]);
        end
    endtask

    task automatic test_back_to_back();
        int chg, stray;
        run_to(902);
        chg = 0;
        stray = 0;
        for (int e = 390; e <= 900; e++) begin
            if (dl_h[e] !== 16'hA5C3 || dr_h[e] !== 16'h3C5A) chg++;
            if (vld_h[e] !== 1'b0) stray++;
        end
        checks++;
        if (chg !== 0 || stray !== 0) begin
            errors++;
            $display("FAIL b2b_hold: changed=%0d stray_vld=%0d expected 0 0", chg, stray);
        end
        checks++;
        if (vld_h[901] !== 1'b1 || vld_h[902] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_valid: vld@901=%b vld@902=%b expected 1 0", vld_h[901], vld_h[902]);
        end
        checks++;
        if (dl_h[901] !== 16'h0001 || dr_h[901] !== 16'h8000) begin
            errors++;
            $display("FAIL b2b_data: l=%h r=%h expected 0001 8000", dl_h[901], dr_h[901]);
        end
    endtask

    task automatic test_ignored_slots();
        run_to(1413);
        checks++;
        if (vld_h[1413] !== 1'b1 || dl_h[1413] !== 16'h0000 || dr_h[1413] !== 16'h0000) begin
            errors++;
            $display("FAIL ignored_slots: vld=%b l=%h r=%h expected 1 0000 0000",
                     vld_h[1413], dl_h[1413], dr_h[1413]);
        end
    endtask

    task automatic test_mid_reset();
        int extra;
        run_to(1925);
        checks++;
        if (vld_h[1925] !== 1'b1 || dl_h[1925] !== 16'hFFFF || dr_h[1925] !== 16'hFFFF) begin
            errors++;
            $display("FAIL full_pair: vld=%b l=%h r=%h expected 1 ffff ffff",
                     vld_h[1925], dl_h[1925], dr_h[1925]);
        end
        // Edge 100 of the left half-frame starting at edge 2048.
        run_to(2148);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({rx_valid, rx_data_l, rx_data_r, sclk, ws} !== 35'd0) begin
            errors++;
            $display("FAIL midrst_clear: vld=%b l=%h r=%h sclk=%b ws=%b expected all 0",
                     rx_valid, rx_data_l, rx_data_r, sclk, ws);
        end
        repeat (5) tick();
        frame_ofs = 5;
        release_reset();
        run_to(600);
        extra = rst_vld;
        for (int e = 1; e <= 600; e++) if (e != 389 && vld_h[e] !== 1'b0) extra++;
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL midrst_stray: %0d unexpected rx_valid, expected 0", extra);
        end
        checks++;
        if (vld_h[389] !== 1'b1 || dl_h[389] !== 16'h1234 || dr_h[389] !== 16'hFEDC) begin
            errors++;
            $display("FAIL midrst_pair: vld=%b l=%h r=%h expected 1 1234 fedc",
                     vld_h[389], dl_h[389], dr_h[389]);
        end
    endtask

    initial begin
        test_reset();
        test_clock();
        test_single_pair();
        test_back_to_back();
        test_ignored_slots();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
